apb_slave_regbank: RTL and testbench

APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

---
 rtl/apb_slave_regbank.sv | 159 +++++++++++++++
 tb/tb_apb_slave_regbank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// APB completer with eight RW registers, an ID word, a transfer counter and a
// programmable wait-state count. All bus outputs are registered.
module apb_slave_regbank #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEF_WAIT   = 0,
  parameter logic [31:0] ID_VALUE   = 32'h4150_4231
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned NREG = 8;
  localparam logic [2:0]  DEF_WAIT_L = 3'(DEF_WAIT);
  localparam logic [ADDR_WIDTH-1:0] OFF_ID   = ADDR_WIDTH'(32'h20);
  localparam logic [ADDR_WIDTH-1:0] OFF_CNT  = ADDR_WIDTH'(32'h24);
  localparam logic [ADDR_WIDTH-1:0] OFF_WAIT = ADDR_WIDTH'(32'h28);

  // The setup phase is recognised while still in IDLE, so that a W=0 transfer
  // can present a registered pready in its first access cycle.
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] xfer_cnt;
  logic [2:0]            wait_cfg;
  logic [2:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            strb_q;

  logic                  setup;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic                  dec_write;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] dec_rdata;
  logic [DATA_WIDTH-1:0] resp_data;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [3:0]            strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign setup  = (state == ST_IDLE) && psel && !penable;
  assign commit = (state == ST_ACCESS) && pready && psel && penable;

  // Decode the live bus during setup and the captured copy afterwards.
  assign dec_addr  = (state == ST_IDLE) ? paddr  : addr_q;
  assign dec_write = (state == ST_IDLE) ? pwrite : write_q;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_err   = 1'b0;
    dec_rdata = '0;
    if (dec_addr[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else if (dec_addr < OFF_ID) begin
      dec_rdata = regs[dec_addr[4:2]];
    end else if (dec_addr == OFF_ID) begin
      dec_rdata = ID_VALUE;
      dec_err   = dec_write;
    end else if (dec_addr == OFF_CNT) begin
      dec_rdata = xfer_cnt;
      dec_err   = dec_write;
    end else if (dec_addr == OFF_WAIT) begin
      dec_rdata = {{(DATA_WIDTH-3){1'b0}}, wait_cfg};
    end else begin
      dec_err = 1'b1;
    end
    resp_data = (dec_err || dec_write) ? '0 : dec_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state    <= ST_IDLE;
      // NOTE: the register bank is plain flops, not a RAM macro, so it is cleared by reset like any other state.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      xfer_cnt <= '0;
      wait_cfg <= DEF_WAIT_L;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            addr_q   <= paddr;
            write_q  <= pwrite;
            wdata_q  <= pwdata;
            strb_q   <= pstrb;
            wait_cnt <= wait_cfg;
            state    <= ST_ACCESS;
            if (wait_cfg == 3'd0) begin
              pready  <= 1'b1;
              pslverr <= dec_err;
              prdata  <= resp_data;
            end
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            state   <= ST_IDLE;
          end else if (!psel) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
              pready  <= 1'b1;
              pslverr <= dec_err;
              prdata  <= resp_data;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Errored transfers still count; only error-free writes touch registers.
      if (commit) begin
        xfer_cnt <= xfer_cnt + 1'b1;
        if (write_q && !dec_err) begin
          if (addr_q < OFF_ID) begin
            regs[addr_q[4:2]] <= merge_bytes(regs[addr_q[4:2]], wdata_q, strb_q);
          end else if (addr_q == OFF_WAIT && strb_q[0]) begin
            wait_cfg <= wdata_q[2:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: a reference model predicts each
// transfer's latency, response and read data, which are checked at pready.
module tb_apb_slave_regbank;

  localparam int          AW    = 16;
  localparam int          DEF_W = 0;
  localparam logic [31:0] ID    = 32'h4150_4231;

  logic          clk = 1'b0;
  logic          presetn = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [31:0]   pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;

  apb_slave_regbank #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(32),
    .DEF_WAIT  (DEF_W),
    .ID_VALUE  (ID)
  ) dut (
    .pclk   (clk),
    .presetn(presetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          is_read;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_reg [8];
  logic [31:0] m_cnt;
  logic [2:0]  m_wait;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_cnt  = '0;
    m_wait = 3'(DEF_W);
  endtask

  function automatic bit m_err(input logic [AW-1:0] a, input bit wr);
    if (a[1:0] != 2'b00 || a > 16'h28) return 1'b1;
    return wr && (a == 16'h20 || a == 16'h24);
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (a < 16'h20) return m_reg[a[4:2]];
    case (a)
      16'h20:  return ID;
      16'h24:  return m_cnt;
      16'h28:  return {29'b0, m_wait};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_commit(input logic [AW-1:0] a, input bit wr, input logic [31:0] wd,
                          input logic [3:0] st);
    if (wr && !m_err(a, wr)) begin
      if (a < 16'h20) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) m_reg[a[4:2]][b*8 +: 8] = wd[b*8 +: 8];
      end else if (a == 16'h28 && st[0]) begin
        m_wait = wd[2:0];
      end
    end
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic check_quiet(input string tag);
    n_vec++;
    if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0) begin
      n_err++;
      $display("FAIL %s quiet outputs: pready=%b prdata=%h pslverr=%b, required 0/00000000/0",
               tag, pready, prdata, pslverr);
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus released.
  task automatic xfer(input logic [AW-1:0] a, input bit wr, input logic [31:0] wd,
                      input logic [3:0] st, input string tag);
    exp_t e;
    exp_t g;
    int   cyc;
    bit   done;
    e.err     = m_err(a, wr);
    e.is_read = !wr;
    e.rdata   = e.err ? 32'h0 : m_read(a);
    e.cycles  = int'(m_wait) + 1;
    sb.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      cyc++;
      if (pready === 1'b1) begin
        done = 1'b1;
      end else begin
        check_quiet(tag);
        paddr  = AW'($urandom);
        pwdata = $urandom;
        pstrb  = 4'($urandom);
        pwrite = 1'($urandom);
        @(negedge clk);
      end
    end
    g = sb.pop_front();
    n_vec++;
    if (!done || cyc != g.cycles) begin
      n_err++;
      $display("FAIL %s latency: pready seen=%b after %0d access cycles, required %0d",
               tag, done, cyc, g.cycles);
    end
    n_vec++;
    if (pslverr !== g.err) begin
      n_err++;
      $display("FAIL %s pslverr: got %b, required %b", tag, pslverr, g.err);
    end
    if (g.is_read || g.err) begin
      n_vec++;
      if (prdata !== g.rdata) begin
        n_err++;
        $display("FAIL %s prdata: got %h, required %h", tag, prdata, g.rdata);
      end
    end
    if (done) m_commit(a, wr, wd, st);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    presetn = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");
  endtask

  task automatic test_basic();
    xfer(16'h04, 1'b1, 32'hDEAD_BEEF, 4'hF, "wr_04");
    xfer(16'h04, 1'b0, 32'h0, 4'h0, "rd_04");
    xfer(16'h20, 1'b0, 32'h0, 4'h0, "rd_id");
  endtask

  task automatic test_wait_cfg();
    xfer(16'h28, 1'b1, 32'h0000_0005, 4'hF, "wr_wait5");
    xfer(16'h08, 1'b1, 32'h1122_3344, 4'b0101, "wr_08_strb");
    xfer(16'h08, 1'b0, 32'h0, 4'h0, "rd_08");
    xfer(16'h28, 1'b0, 32'h0, 4'h0, "rd_wait5");
    xfer(16'h28, 1'b1, 32'hFFFF_FFF8, 4'hF, "wr_wait0");
    xfer(16'h28, 1'b0, 32'h0, 4'h0, "rd_wait0");
  endtask

  task automatic test_strobe_zero();
    xfer(16'h10, 1'b1, 32'hAAAA_5555, 4'hF, "wr_10");
    xfer(16'h10, 1'b1, 32'h1234_5678, 4'h0, "wr_10_nostrb");
    xfer(16'h10, 1'b0, 32'h0, 4'h0, "rd_10");
  endtask

  task automatic test_errors();
    xfer(16'h2C, 1'b0, 32'h0, 4'h0, "err_rd_2c");
    xfer(16'h20, 1'b1, 32'h1111_1111, 4'hF, "err_wr_id");
    xfer(16'h24, 1'b1, 32'h2222_2222, 4'hF, "err_wr_cnt");
    xfer(16'h02, 1'b0, 32'h0, 4'h0, "err_rd_02");
    xfer(16'h06, 1'b1, 32'h3333_3333, 4'hF, "err_wr_06");
    xfer(16'h1000, 1'b0, 32'h0, 4'h0, "err_rd_far");
    xfer(16'h04, 1'b0, 32'h0, 4'h0, "rd_04_after_err");
    xfer(16'h24, 1'b0, 32'h0, 4'h0, "rd_cnt");
    xfer(16'h20, 1'b0, 32'h0, 4'h0, "rd_id_after_err");
  endtask

  task automatic test_penable_idle();
    psel = 1'b0; penable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("penable_idle");
    end
    psel = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_quiet("psel_penable_idle");
    end
    idle(1);
    xfer(16'h24, 1'b0, 32'h0, 4'h0, "rd_cnt_after_idle");
  endtask

  task automatic test_abort();
    xfer(16'h28, 1'b1, 32'h3, 4'hF, "wr_wait3");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h00;
    pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    check_quiet("abort_acc1");
    @(negedge clk);
    check_quiet("abort_acc2");
    psel = 1'b0; penable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_quiet("abort_after");
    end
    xfer(16'h00, 1'b0, 32'h0, 4'h0, "rd_00_after_abort");
    xfer(16'h24, 1'b0, 32'h0, 4'h0, "rd_cnt_after_abort");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    bit            wr;
    for (int i = 0; i < 24; i++) begin
      a  = AW'($urandom_range(0, 12) * 4);
      if ($urandom_range(0, 7) == 0) a = a | AW'($urandom_range(1, 3));
      wr = 1'($urandom);
      xfer(a, wr, $urandom, 4'($urandom), "b2b");
    end
    xfer(16'h24, 1'b0, 32'h0, 4'h0, "rd_cnt_b2b");
  endtask

  task automatic test_wrap();
    force dut.xfer_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    m_cnt = 32'hFFFF_FFFF;
    xfer(16'h0C, 1'b1, 32'h0000_0055, 4'hF, "wr_0c_wrap");
    xfer(16'h24, 1'b0, 32'h0, 4'h0, "rd_cnt_wrapped");
  endtask

  task automatic test_reset_mid();
    xfer(16'h28, 1'b1, 32'h3, 4'hF, "wr_wait3_again");
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h04;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_quiet("reset_mid");
    presetn = 1'b1;
    m_reset();
    @(negedge clk);
    xfer(16'h28, 1'b0, 32'h0, 4'h0, "rd_wait_post_reset");
    xfer(16'h04, 1'b0, 32'h0, 4'h0, "rd_04_post_reset");
    xfer(16'h24, 1'b0, 32'h0, 4'h0, "rd_cnt_post_reset");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wait_cfg();
    test_strobe_zero();
    test_errors();
    test_penable_idle();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
